// File: rtl/rc4_pkg.sv
// Shared RC4 decrypt definitions: FSM state encoding, S-box size and the
// printable-text character bounds used to judge a decrypted byte.
package rc4_pkg;

    localparam int S_SIZE = 256;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        KSA_RD_I,
        KSA_RD_J,
        KSA_WR,
        PRGA_RD_I,
        PRGA_RD_J,
        PRGA_WR,
        PRGA_RD_F,
        PRGA_XOR,
        DONE
    } rc4_state_t;

    function automatic logic is_text_char(input logic [7:0] b);
        return (b == CHAR_SPACE) || ((b >= CHAR_LO) && (b <= CHAR_HI));
    endfunction

endpackage

// File: rtl/rc4_decrypt_core_if.sv
// Control, status and ROM/RAM bus of the RC4 decrypt core; the core uses
// the slave view, the surrounding system (or bench) the master view.
interface rc4_decrypt_core_if #(
    parameter int KEY_BYTES = 3
);
    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic                   busy;
    logic                   done;
    logic                   key_valid;
    logic [7:0]             fail_index;
    logic [7:0]             rom_addr;
    logic [7:0]             rom_q;
    logic [7:0]             ram_addr;
    logic [7:0]             ram_data;
    logic                   ram_wren;

    modport master (
        output start, secret_key, rom_q,
        input  busy, done, key_valid, fail_index, rom_addr,
        input  ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  start, secret_key, rom_q,
        output busy, done, key_valid, fail_index, rom_addr,
        output ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/rc4_sbox_ram.sv
// 256x8 single-port S-box RAM, synchronous read with one cycle of latency.
// Read-during-write returns the previous contents of the addressed entry.
module rc4_sbox_ram
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic       wren,
    input  logic [7:0] wdata,
    output logic [7:0] q
);
    logic [7:0] mem [S_SIZE];

    always_ff @(posedge clk) begin
        if (wren) mem[addr] <= wdata;
        q <= mem[addr];
    end
endmodule

// File: rtl/rc4_decrypt_core.sv
// RC4 decrypt core: KSA + PRGA over an internal S-box, XOR with ROM ciphertext.
// Optional macro RC4_EARLY_ABORT_EN stops after writing the first invalid byte.
module rc4_decrypt_core
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    rc4_decrypt_core_if.slave bus
);
    localparam int         KEY_W  = 8 * KEY_BYTES;
    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);
    localparam logic [7:0] LAST_I = 8'(S_SIZE - 1);

    rc4_state_t state, state_next;

    logic [7:0]       i, j, k, si, sj;
    logic             phase;
    logic [KEY_W-1:0] key_sr;
    logic [7:0]       key_byte;
    logic [7:0]       sbox_addr, sbox_wdata, sbox_q;
    logic             sbox_we;
    logic [7:0]       plain;
    logic             last_byte, abort;
    logic             key_valid, ram_wren;
    logic [7:0]       fail_index, ram_addr, ram_data;

    rc4_sbox_ram u_sbox (
        .clk   (CLOCK_50),
        .addr  (sbox_addr),
        .wren  (sbox_we),
        .wdata (sbox_wdata),
        .q     (sbox_q)
    );

    // key_sr rotates one byte per KSA step, so its top byte is key[i mod KEY_BYTES]
    assign key_byte  = key_sr[KEY_W-1 -: 8];
    assign plain     = bus.rom_q ^ sbox_q;
    assign last_byte = (k == LAST_K);
`ifdef RC4_EARLY_ABORT_EN
    assign abort = !is_text_char(plain);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Swaps take two WR cycles: phase 0 writes S[i]=S[j], phase 1 writes S[j]=old S[i]
    always_comb begin
        state_next = state;
        sbox_addr  = i;
        sbox_we    = 1'b0;
        sbox_wdata = 8'h00;
        case (state)
            IDLE, DONE: if (bus.start) state_next = INIT;
            INIT: begin
                sbox_we    = 1'b1;
                sbox_wdata = i;
                if (i == LAST_I) state_next = KSA_RD_I;
            end
            KSA_RD_I: state_next = KSA_RD_J;
            KSA_RD_J: begin
                sbox_addr  = j + sbox_q + key_byte;
                state_next = KSA_WR;
            end
            KSA_WR, PRGA_WR: begin
                sbox_we = 1'b1;
                if (!phase) begin
                    sbox_addr  = i;
                    sbox_wdata = sbox_q;
                end else begin
                    sbox_addr  = j;
                    sbox_wdata = si;
                    if (state == PRGA_WR)  state_next = PRGA_RD_F;
                    else if (i == LAST_I)  state_next = PRGA_RD_I;
                    else                   state_next = KSA_RD_I;
                end
            end
            PRGA_RD_I: begin
                sbox_addr  = i + 8'd1;
                state_next = PRGA_RD_J;
            end
            PRGA_RD_J: begin
                sbox_addr  = j + sbox_q;
                state_next = PRGA_WR;
            end
            PRGA_RD_F: begin
                sbox_addr  = si + sj;
                state_next = PRGA_XOR;
            end
            PRGA_XOR: if (last_byte || abort) state_next = DONE;
                      else                    state_next = PRGA_RD_I;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            i          <= 8'h00;
            k          <= 8'h00;
            phase      <= 1'b0;
            key_valid  <= 1'b0;
            fail_index <= 8'h00;
            ram_wren   <= 1'b0;
            ram_addr   <= 8'h00;
            ram_data   <= 8'h00;
        end else begin
            ram_wren <= 1'b0;
            case (state)
                IDLE, DONE: if (bus.start) begin
                    i          <= 8'h00;
                    k          <= 8'h00;
                    phase      <= 1'b0;
                    key_valid  <= 1'b1;
                    fail_index <= 8'h00;
                end
                INIT: i <= i + 8'd1;
                KSA_WR, PRGA_WR: begin
                    phase <= ~phase;
                    if (phase && (state == KSA_WR)) i <= i + 8'd1;
                end
                PRGA_RD_I: i <= i + 8'd1;
                PRGA_XOR: begin
                    ram_wren <= 1'b1;
                    ram_addr <= k;
                    ram_data <= plain;
                    if (key_valid && !is_text_char(plain)) begin
                        key_valid  <= 1'b0;
                        fail_index <= k;
                    end
                    if (!last_byte && !abort) k <= k + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        case (state)
            IDLE, DONE: if (bus.start) j <= 8'h00;
            INIT: begin
                j      <= 8'h00;
                key_sr <= bus.secret_key;
            end
            KSA_RD_J, PRGA_RD_J: begin
                si <= sbox_q;
                j  <= sbox_addr;
            end
            KSA_WR, PRGA_WR: begin
                if (!phase) sj <= sbox_q;
                if (phase && (state == KSA_WR)) begin
                    key_sr <= (key_sr << 8) | (key_sr >> (KEY_W - 8));
                    if (i == LAST_I) j <= 8'h00;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy       = (state != IDLE) && (state != DONE);
    assign bus.done       = (state == DONE);
    assign bus.key_valid  = key_valid;
    assign bus.fail_index = fail_index;
    assign bus.rom_addr   = k;
    assign bus.ram_addr   = ram_addr;
    assign bus.ram_data   = ram_data;
    assign bus.ram_wren   = ram_wren;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: three configurations against a software RC4 model.
module tb_rc4_decrypt_core;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       kv;
        logic [7:0] fi;
        logic [7:0] raddr;
        logic       wren;
        logic [7:0] waddr;
        logic [7:0] wdata;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_v   [3];
    logic         start_v [3];
    logic [127:0] key_v   [3];
    logic         clr     [3];
    obs_t         obs     [3];
    logic [7:0]   rom      [3][256];
    logic [7:0]   cap_addr [3][256];
    logic [7:0]   cap_data [3][256];
    int           cnt      [3];

    logic [7:0]   m_ks  [256];
    logic [7:0]   m_out [256];
    int           m_kv, m_fi, m_nw;
    int           n_tests = 0;
    int           n_fail  = 0;

    logic [7:0] ROM_KEY  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] EXP_KEY  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ROM_WIKI [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] EXP_WIKI [5] = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

    always #5 clk = ~clk;

    rc4_decrypt_core_if #(.KEY_BYTES(3)) bus_a ();
    rc4_decrypt_core_if #(.KEY_BYTES(4)) bus_b ();
    rc4_decrypt_core_if #(.KEY_BYTES(1)) bus_c ();

    rc4_decrypt_core #(.KEY_BYTES(3), .MSG_LEN(9))  u_a (.CLOCK_50(clk), .reset(rst_v[0]), .bus(bus_a));
    rc4_decrypt_core #(.KEY_BYTES(4), .MSG_LEN(5))  u_b (.CLOCK_50(clk), .reset(rst_v[1]), .bus(bus_b));
    rc4_decrypt_core #(.KEY_BYTES(1), .MSG_LEN(16)) u_c (.CLOCK_50(clk), .reset(rst_v[2]), .bus(bus_c));

    assign bus_a.start = start_v[0];
    assign bus_b.start = start_v[1];
    assign bus_c.start = start_v[2];
    assign bus_a.secret_key = key_v[0][23:0];
    assign bus_b.secret_key = key_v[1][31:0];
    assign bus_c.secret_key = key_v[2][7:0];

    assign obs[0] = {bus_a.busy, bus_a.done, bus_a.key_valid, bus_a.fail_index, bus_a.rom_addr,
                     bus_a.ram_wren, bus_a.ram_addr, bus_a.ram_data};
    assign obs[1] = {bus_b.busy, bus_b.done, bus_b.key_valid, bus_b.fail_index, bus_b.rom_addr,
                     bus_b.ram_wren, bus_b.ram_addr, bus_b.ram_data};
    assign obs[2] = {bus_c.busy, bus_c.done, bus_c.key_valid, bus_c.fail_index, bus_c.rom_addr,
                     bus_c.ram_wren, bus_c.ram_addr, bus_c.ram_data};

    // ROMs with one cycle of read latency
    always @(posedge clk) begin
        bus_a.rom_q <= rom[0][bus_a.rom_addr];
        bus_b.rom_q <= rom[1][bus_b.rom_addr];
        bus_c.rom_q <= rom[2][bus_c.rom_addr];
    end

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (clr[s]) cnt[s] <= 0;
            else if (obs[s].wren) begin
                if (cnt[s] < 256) begin
                    cap_addr[s][cnt[s]] <= obs[s].waddr;
                    cap_data[s][cnt[s]] <= obs[s].wdata;
                end
                cnt[s] <= cnt[s] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic logic char_ok(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    // Plain textbook RC4 keystream
    task automatic gen_ks(input int kb, input int n, input logic [127:0] keyv);
        int S [256];
        int i, j, t, kbyte;
        for (int x = 0; x < 256; x++) S[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kbyte = int'(keyv[8*(kb-1-(x % kb)) +: 8]);
            j = (j + S[x] + kbyte) % 256;
            t = S[x]; S[x] = S[j]; S[j] = t;
        end
        i = 0; j = 0;
        for (int w = 0; w < n; w++) begin
            i = (i + 1) % 256;
            j = (j + S[i]) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            m_ks[w] = 8'(S[(S[i] + S[j]) % 256]);
        end
    endtask

    task automatic make_rom(input int s, input int kb, input int n, input logic [127:0] keyv, input int bad);
        int r;
        logic [7:0] pt;
        gen_ks(kb, n, keyv);
        for (int w = 0; w < n; w++) begin
            r  = int'($urandom_range(0, 26));
            pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            if (w == bad) pt = 8'(8'h41 + $urandom_range(0, 25));
            rom[s][w] = pt ^ m_ks[w];
        end
    endtask

    task automatic start_run(input int s);
        clr[s]     = 1'b1;
        start_v[s] = 1'b1;
        @(negedge clk);
        #1;
        clr[s]     = 1'b0;
        start_v[s] = 1'b0;
    endtask

    task automatic run_check(input int s, input int kb, input int n, input logic [127:0] keyv,
                             input int pulse_k, input string tag);
        gen_ks(kb, n, keyv);
        m_kv = 1; m_fi = 0; m_nw = n;
        for (int w = 0; w < n; w++) begin
            m_out[w] = rom[s][w] ^ m_ks[w];
            if (!char_ok(m_out[w]) && (m_kv == 1)) begin
                m_kv = 0;
                m_fi = w;
            end
        end
`ifdef RC4_EARLY_ABORT_EN
        if (m_kv == 0) m_nw = m_fi + 1;
`endif
        key_v[s] = keyv;
        start_run(s);
        check({tag, "_busy_after_start"}, 32'(obs[s].busy), 32'd1);
        if (pulse_k >= 0) begin
            repeat (20) @(negedge clk);
            start_v[s] = 1'b1; @(negedge clk); start_v[s] = 1'b0;
            for (int c = 0; c < 4000 && obs[s].raddr != 8'(pulse_k); c++) @(negedge clk);
            check({tag, "_reach_pulse_k"}, 32'(obs[s].raddr), 32'(pulse_k));
            start_v[s] = 1'b1; @(negedge clk); start_v[s] = 1'b0;
        end
        for (int c = 0; c < 4000 && !obs[s].done; c++) @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, "_done"},   32'(obs[s].done), 32'd1);
        check({tag, "_busy"},   32'(obs[s].busy), 32'd0);
        check({tag, "_kv"},     32'(obs[s].kv),   32'(m_kv));
        if (m_kv == 0) check({tag, "_fi"}, 32'(obs[s].fi), 32'(m_fi));
        check({tag, "_writes"}, 32'(cnt[s]), 32'(m_nw));
        for (int w = 0; w < m_nw && w < 256; w++) begin
            check($sformatf("%s_addr%0d", tag, w), 32'(cap_addr[s][w]), 32'(w));
            check($sformatf("%s_data%0d", tag, w), 32'(cap_data[s][w]), 32'(m_out[w]));
        end
    endtask

    task automatic check_wiki(input string tag);
        check({tag, "_const_kv"}, 32'(obs[1].kv), 32'd1);
        check({tag, "_const_writes"}, 32'(cnt[1]), 32'd5);
        for (int w = 0; w < 5; w++)
            check($sformatf("%s_const%0d", tag, w), 32'(cap_data[1][w]), 32'(EXP_WIKI[w]));
    endtask

    initial begin
        logic [127:0] kr;
        int nw;
        for (int s = 0; s < 3; s++) begin
            rst_v[s] = 1'b1; start_v[s] = 1'b0; key_v[s] = '0; clr[s] = 1'b1;
            for (int w = 0; w < 256; w++) rom[s][w] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d_busy", s),  32'(obs[s].busy),  32'd0);
            check($sformatf("rst%0d_done", s),  32'(obs[s].done),  32'd0);
            check($sformatf("rst%0d_kv", s),    32'(obs[s].kv),    32'd0);
            check($sformatf("rst%0d_fi", s),    32'(obs[s].fi),    32'd0);
            check($sformatf("rst%0d_wren", s),  32'(obs[s].wren),  32'd0);
            check($sformatf("rst%0d_raddr", s), 32'(obs[s].raddr), 32'd0);
            check($sformatf("rst%0d_waddr", s), 32'(obs[s].waddr), 32'd0);
            check($sformatf("rst%0d_wdata", s), 32'(obs[s].wdata), 32'd0);
            rst_v[s] = 1'b0;
            clr[s]   = 1'b0;
        end

        // "Key" / "Plaintext": first byte 'P' is invalid
        for (int w = 0; w < 9; w++) rom[0][w] = ROM_KEY[w];
        run_check(0, 3, 9, 128'h4B6579, -1, "key");
`ifdef RC4_EARLY_ABORT_EN
        nw = 1;
`else
        nw = 9;
`endif
        check("key_const_writes", 32'(cnt[0]), 32'(nw));
        check("key_const_kv", 32'(obs[0].kv), 32'd0);
        check("key_const_fi", 32'(obs[0].fi), 32'd0);
        for (int w = 0; w < nw; w++)
            check($sformatf("key_const%0d", w), 32'(cap_data[0][w]), 32'(EXP_KEY[w]));

        // "Wiki" / "pedia" with start pulses while busy, then restart from DONE
        for (int w = 0; w < 5; w++) rom[1][w] = ROM_WIKI[w];
        run_check(1, 4, 5, 128'h57696B69, 2, "wiki_pulse");
        check_wiki("wiki_pulse");
        run_check(1, 4, 5, 128'h57696B69, -1, "wiki_redo");
        check_wiki("wiki_redo");

        // Reset mid-PRGA at k=3
        start_run(1);
        for (int c = 0; c < 4000 && obs[1].raddr != 8'd3; c++) @(negedge clk);
        check("rst_mid_reach_k3", 32'(obs[1].raddr), 32'd3);
        #1 rst_v[1] = 1'b1;
        #1;
        check("rst_mid_busy", 32'(obs[1].busy), 32'd0);
        check("rst_mid_done", 32'(obs[1].done), 32'd0);
        check("rst_mid_wren", 32'(obs[1].wren), 32'd0);
        check("rst_mid_kv",   32'(obs[1].kv),   32'd0);
        @(negedge clk);
        rst_v[1] = 1'b0;
        run_check(1, 4, 5, 128'h57696B69, -1, "wiki_post_rst");
        check_wiki("wiki_post_rst");

        // KEY_BYTES=1, key 0x00 forces i==j at KSA i=0
        make_rom(2, 1, 16, 128'h0, int'($urandom_range(0, 16)));
        run_check(2, 1, 16, 128'h0, -1, "kb1_zero");

        for (int t = 0; t < 3; t++) begin
            kr = {96'h0, $urandom()};
            make_rom(2, 1, 16, kr, int'($urandom_range(0, 20)));
            run_check(2, 1, 16, kr, -1, $sformatf("kb1_rand%0d", t));
        end
        for (int t = 0; t < 2; t++) begin
            kr = {96'h0, $urandom()};
            make_rom(0, 3, 9, kr, int'($urandom_range(0, 12)));
            run_check(0, 3, 9, kr, -1, $sformatf("kb3_rand%0d", t));
            kr = {96'h0, $urandom()};
            make_rom(1, 4, 5, kr, int'($urandom_range(0, 7)));
            run_check(1, 4, 5, kr, -1, $sformatf("kb4_rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_core.md
RC4_DECRYPT_CORE -- requirements
Module: rc4_decrypt_core

Interface
REQ-001 Parameter KEY_BYTES, default 3, number of secret-key bytes (1..16).
REQ-002 Parameter MSG_LEN, default 32, number of message bytes to decrypt (1..256).
REQ-003 Port CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port start  in  1  request to run; sampled only in IDLE.
REQ-006 Port secret_key  in  8*KEY_BYTES  key; key byte 0 = most-significant byte.
REQ-007 Port busy  out  1  high in every state except IDLE and DONE.
REQ-008 Port done  out  1  high in DONE.
REQ-009 Port key_valid  out  1  meaningful when done=1; 1 = every decrypted byte is valid.
REQ-010 Port fail_index  out  8  index of the first invalid byte; meaningful when done=1 and key_valid=0.
REQ-011 Port rom_addr  out  8  encrypted-message ROM address; rom_q is valid one cycle after the address is presented.
REQ-012 Port rom_q  in  8  encrypted-message ROM data.
REQ-013 Ports ram_addr  out  8, ram_data  out  8, ram_wren  out  1  decrypted-message RAM write port.

Function
REQ-014 S-box SHALL be a 256x8 single-port RAM with synchronous read (1-cycle latency), internal to the block.
REQ-015 FSM states: IDLE, INIT, KSA_RD_I, KSA_RD_J, KSA_WR, PRGA_RD_I, PRGA_RD_J, PRGA_WR, PRGA_RD_F, PRGA_XOR, DONE.
REQ-016 IDLE: if start=1, go to INIT and clear i, j, k, key_valid (set to 1) and fail_index (set to 0).
REQ-017 INIT: write S[i]=i for i=0..255, one write per cycle (256 cycles), then go to KSA with i=0 and j=0.
REQ-018 KSA per i: j = j + S[i] + key[i mod KEY_BYTES], all mod 256, then swap S[i] and S[j]; run for i=0..255, then go to PRGA with i=0, j=0, k=0.
REQ-019 Swap SHALL read both values before writing either; when i==j the result SHALL leave S unchanged.
REQ-020 PRGA per k: i=i+1, j=j+S[i], swap S[i] and S[j], f=S[(S[i]+S[j]) mod 256], fetch rom_q at address k, then write ram_addr=k and ram_data=rom_q^f with ram_wren high for exactly one cycle.
REQ-021 A byte is valid iff it equals 0x20 or lies in 0x61..0x7A; on the first invalid byte, key_valid=0 and fail_index=k.
REQ-022 After the write for k==MSG_LEN-1, go to DONE; k and the addresses never exceed MSG_LEN-1.
REQ-023 DONE: hold all outputs; start=1 restarts the run exactly as from IDLE.
REQ-024 All 8-bit index arithmetic wraps modulo 256; i=255 increments to 0 with no error.
REQ-025 start asserted while busy=1 SHALL be ignored.

Reset
REQ-026 reset=1 at any time, including mid-run, forces IDLE immediately.
REQ-027 On reset: busy=0, done=0, key_valid=0, fail_index=0, ram_wren=0, rom_addr=0, ram_addr=0, ram_data=0.
REQ-028 S-box contents after reset are undefined; INIT on every run makes this irrelevant.

Configuration
REQ-029 Macro RC4_EARLY_ABORT_EN: when defined, the first invalid byte is still written, then the FSM goes directly to DONE with key_valid=0.
REQ-030 Without RC4_EARLY_ABORT_EN, all MSG_LEN bytes are always processed and written.

Structure
REQ-031 Package rc4_pkg SHALL hold the FSM state enum, the S_SIZE=256 constant, and the valid-character bounds (0x20, 0x61, 0x7A).
REQ-032 S-box SHALL be a sub-module, rc4_sbox_ram (256x8, synchronous read, write enable).

Verification
REQ-033 KEY_BYTES=3, MSG_LEN=9, key 0x4B6579 ("Key"), ROM = BB F3 16 E8 D9 40 AF 0A D3 -> RAM = "Plaintext" (50 6C 61 69 6E 74 65 78 74); key_valid=0, fail_index=0; nine ram_wren pulses.
REQ-034 Same stimulus with RC4_EARLY_ABORT_EN defined -> exactly one write (addr 0, data 0x50), then done=1, key_valid=0, fail_index=0.
REQ-035 KEY_BYTES=4, MSG_LEN=5, key 0x57696B69 ("Wiki"), ROM = 10 21 BF 04 20 -> RAM = "pedia"; key_valid=1.
REQ-036 Assert reset during PRGA at k=3 -> next cycle busy=0, done=0, ram_wren=0; a fresh start then reproduces the REQ-035 result.
REQ-037 Pulse start while busy=1 -> no effect on the run; pulse start in DONE -> busy=1 next cycle and identical output repeats.
REQ-038 Check that the key-byte pattern selected for KEY_BYTES=1 gives i==j in KSA at least once -> S remains a permutation and the final output matches a software model.
